// File: rtl/instr_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding,
// PC increment and default reset PC.
package instr_fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        REQ   = 2'b01,
        DRAIN = 2'b10
    } fetch_state_t;

    localparam int          PC_INCR          = 4;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch stage bus bundle: instruction-memory req/ack port, redirect input
// and the valid/ready link to decode. master = fetch unit, slave = environment.
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              IMemReq;
    logic [ADDR_W-1:0] IMemAddr;
    logic              IMemAck;
    logic [DATA_W-1:0] IMemData;
    logic              Redirect;
    logic [ADDR_W-1:0] RedirectPC;
    logic              InstrValid;
    logic [DATA_W-1:0] Instr;
    logic [ADDR_W-1:0] InstrPC;
    logic [ADDR_W-1:0] InstrPCPlus4;
    logic              DecodeReady;

    modport master (
        output IMemReq, IMemAddr, InstrValid, Instr, InstrPC, InstrPCPlus4,
        input  IMemAck, IMemData, Redirect, RedirectPC, DecodeReady
    );

    modport slave (
        input  IMemReq, IMemAddr, InstrValid, Instr, InstrPC, InstrPCPlus4,
        output IMemAck, IMemData, Redirect, RedirectPC, DecodeReady
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, runs one instruction-memory read at a time and
// holds the fetched word in a single output slot for decode. Redirects flush
// the slot; a redirect during an outstanding read parks in DRAIN until the
// stale ack returns.
// Optional build macro FETCH_PERF_EN adds FetchCount/FlushCount outputs.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
    input  logic                 Clk,
    input  logic                 Reset,
    instr_fetch_unit_if.master   bus
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]          FetchCount,
    output logic [31:0]          FlushCount
`endif
);

    fetch_state_t      state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic              req, req_n;
    logic [ADDR_W-1:0] addr, addr_n;
    logic              valid, valid_n;
    logic [DATA_W-1:0] instr, instr_n;
    logic [ADDR_W-1:0] ipc, ipc_n;
    logic [ADDR_W-1:0] ipc4, ipc4_n;

    logic [ADDR_W-1:0] redirect_pc;
    logic [ADDR_W-1:0] addr_plus4;

    // Low two bits of the target are dropped so every fetch is word-aligned.
    assign redirect_pc = bus.RedirectPC & ~ADDR_W'(3);
    assign addr_plus4  = addr + ADDR_W'(PC_INCR);

    assign bus.IMemReq      = req;
    assign bus.IMemAddr     = addr;
    assign bus.InstrValid   = valid;
    assign bus.Instr        = instr;
    assign bus.InstrPC      = ipc;
    assign bus.InstrPCPlus4 = ipc4;

    // Next-state and datapath updates; redirect beats delivery and consumption.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        req_n   = req;
        addr_n  = addr;
        valid_n = valid & ~bus.DecodeReady;
        instr_n = instr;
        ipc_n   = ipc;
        ipc4_n  = ipc4;
        unique case (state)
            IDLE: begin
                if (bus.Redirect) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end else if (!valid || bus.DecodeReady) begin
                    req_n   = 1'b1;
                    addr_n  = pc;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (bus.IMemAck && !bus.Redirect) begin
                    instr_n = bus.IMemData;
                    ipc_n   = addr;
                    ipc4_n  = addr_plus4;
                    valid_n = 1'b1;
                    pc_n    = addr_plus4;
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (bus.IMemAck) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                    req_n   = 1'b0;
                    state_n = IDLE;
                end else if (bus.Redirect) begin
                    // Request must stay up until memory acks the stale read.
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                    state_n = DRAIN;
                end
            end
            DRAIN: begin
                if (bus.Redirect) begin
                    pc_n    = redirect_pc;
                    valid_n = 1'b0;
                end
                if (bus.IMemAck) begin
                    req_n   = 1'b0;
                    state_n = IDLE;
                end
            end
            default: begin
                req_n   = 1'b0;
                valid_n = 1'b0;
                state_n = IDLE;
            end
        endcase
    end

    // State, PC, memory request and output slot registers.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            req   <= 1'b0;
            addr  <= '0;
            valid <= 1'b0;
            instr <= '0;
            ipc   <= '0;
            ipc4  <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            req   <= req_n;
            addr  <= addr_n;
            valid <= valid_n;
            instr <= instr_n;
            ipc   <= ipc_n;
            ipc4  <= ipc4_n;
        end
    end

`ifdef FETCH_PERF_EN
    logic xfer;
    // A slot flushed by a same-cycle redirect does not count as delivered.
    assign xfer = valid & bus.DecodeReady & ~bus.Redirect;

    // Free-running wrap-around perf counters.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            FetchCount <= '0;
            FlushCount <= '0;
        end else begin
            if (xfer)         FetchCount <= FetchCount + 32'd1;
            if (bus.Redirect) FlushCount <= FlushCount + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: each step advances one clock edge,
// drives inputs 1 time unit after it and checks outputs at the same point.
module tb_instr_fetch_unit;

    logic Clk;
    logic Reset;
    int   n_vec = 0;
    int   n_err = 0;

    instr_fetch_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

`ifdef FETCH_PERF_EN
    logic [31:0] FetchCount;
    logic [31:0] FlushCount;
`endif

    instr_fetch_unit #(.ADDR_W(32), .DATA_W(32), .RESET_PC(32'h0)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .bus        (bus)
`ifdef FETCH_PERF_EN
        ,
        .FetchCount (FetchCount),
        .FlushCount (FlushCount)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_slot(input string tag, input logic v, input logic [31:0] i,
                            input logic [31:0] pc, input logic [31:0] pc4);
        chk({tag, ".valid"}, {31'd0, bus.InstrValid}, {31'd0, v});
        chk({tag, ".instr"}, bus.Instr, i);
        chk({tag, ".pc"},    bus.InstrPC, pc);
        chk({tag, ".pc4"},   bus.InstrPCPlus4, pc4);
    endtask

    initial begin
        Reset           = 1'b1;
        bus.IMemAck     = 1'b0;
        bus.IMemData    = '0;
        bus.Redirect    = 1'b0;
        bus.RedirectPC  = '0;
        bus.DecodeReady = 1'b1;
        #12;
        chk("rst.req",  {31'd0, bus.IMemReq}, 32'd0);
        chk("rst.addr", bus.IMemAddr, 32'd0);
        chk_slot("rst", 1'b0, 32'd0, 32'd0, 32'd0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        // Zero-wait memory, decode always ready
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h2008_0005;
        step();                                   // edge1: IDLE -> REQ @0
        chk("zw.req0",  {31'd0, bus.IMemReq}, 32'd1);
        chk("zw.addr0", bus.IMemAddr, 32'h0);
        chk("zw.v0",    {31'd0, bus.InstrValid}, 32'd0);
        step();                                   // edge2: ack -> slot
        chk("zw.req_drop", {31'd0, bus.IMemReq}, 32'd0);
        chk_slot("zw.slot0", 1'b1, 32'h2008_0005, 32'h0, 32'h4);
        step();                                   // edge3: consume + REQ @4
        chk("zw.addr1", bus.IMemAddr, 32'h4);
        chk("zw.req1",  {31'd0, bus.IMemReq}, 32'd1);
        chk("zw.v1",    {31'd0, bus.InstrValid}, 32'd0);
        step();                                   // edge4: slot @4
        chk_slot("zw.slot1", 1'b1, 32'h2008_0005, 32'h4, 32'h8);

        // 3-cycle ack delay at address 8
        bus.IMemAck = 1'b0;
        step();                                   // edge5
        chk("dly.addr5", bus.IMemAddr, 32'h8);
        chk("dly.req5",  {31'd0, bus.IMemReq}, 32'd1);
        step();                                   // edge6
        chk("dly.addr6", bus.IMemAddr, 32'h8);
        chk("dly.req6",  {31'd0, bus.IMemReq}, 32'd1);
        step();                                   // edge7
        chk("dly.addr7", bus.IMemAddr, 32'h8);
        chk("dly.v7",    {31'd0, bus.InstrValid}, 32'd0);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h3C01_ABCD;
        step();                                   // edge8: ack
        chk("dly.req8", {31'd0, bus.IMemReq}, 32'd0);
        chk_slot("dly.slot", 1'b1, 32'h3C01_ABCD, 32'h8, 32'hC);

        // Decode stalls for 4 cycles with a full slot
        bus.IMemAck     = 1'b0;
        bus.DecodeReady = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();                               // edges 9..12
            chk("stall.req",   {31'd0, bus.IMemReq}, 32'd0);
            chk("stall.instr", bus.Instr, 32'h3C01_ABCD);
            chk("stall.valid", {31'd0, bus.InstrValid}, 32'd1);
        end
        bus.DecodeReady = 1'b1;
        step();                                   // edge13: consume + REQ @C
        chk("stall.resume_addr", bus.IMemAddr, 32'hC);
        chk("stall.resume_req",  {31'd0, bus.IMemReq}, 32'd1);
        chk("stall.resume_v",    {31'd0, bus.InstrValid}, 32'd0);

        // Redirect while waiting for ack -> DRAIN, stale data dropped
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0043;
        step();                                   // edge14
        chk("drn.req_held",  {31'd0, bus.IMemReq}, 32'd1);
        chk("drn.addr_held", bus.IMemAddr, 32'hC);
        chk("drn.v",         {31'd0, bus.InstrValid}, 32'd0);
        bus.Redirect = 1'b0;
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'hDEAD_BEEF;
        step();                                   // edge15: stale ack
        chk("drn.req_drop", {31'd0, bus.IMemReq}, 32'd0);
        chk("drn.stale_v",  {31'd0, bus.InstrValid}, 32'd0);
        bus.IMemAck = 1'b0;
        step();                                   // edge16: REQ @40
        chk("drn.new_addr", bus.IMemAddr, 32'h40);
        chk("drn.new_req",  {31'd0, bus.IMemReq}, 32'd1);
        chk("drn.new_v",    {31'd0, bus.InstrValid}, 32'd0);
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h1111_2222;
        step();                                   // edge17
        chk_slot("drn.slot", 1'b1, 32'h1111_2222, 32'h40, 32'h44);

        // Redirect on a full slot with decode ready: flushed, no transfer
        bus.IMemAck    = 1'b0;
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0100;
        step();                                   // edge18
        chk("flush.v",   {31'd0, bus.InstrValid}, 32'd0);
        chk("flush.req", {31'd0, bus.IMemReq}, 32'd0);
        bus.Redirect = 1'b0;
        step();                                   // edge19: REQ @100
        chk("flush.addr", bus.IMemAddr, 32'h100);
        // Redirect on the same edge as ack
        bus.IMemAck    = 1'b1;
        bus.IMemData   = 32'h0BAD_0BAD;
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'h0000_0200;
        step();                                   // edge20
        chk("ackrd.v",   {31'd0, bus.InstrValid}, 32'd0);
        chk("ackrd.req", {31'd0, bus.IMemReq}, 32'd0);
        bus.IMemAck  = 1'b0;
        bus.Redirect = 1'b0;
        step();                                   // edge21: REQ @200
        chk("ackrd.addr", bus.IMemAddr, 32'h200);
        chk("ackrd.req2", {31'd0, bus.IMemReq}, 32'd1);

        // Redirect to top of address space (low bits dropped), wrap check
        bus.Redirect   = 1'b1;
        bus.RedirectPC = 32'hFFFF_FFFF;
        step();                                   // edge22: DRAIN
        bus.Redirect = 1'b0;
        bus.IMemAck  = 1'b1;
        bus.IMemData = 32'h0000_000C;
        step();                                   // edge23: stale ack -> IDLE
        chk("wrap.drain_v", {31'd0, bus.InstrValid}, 32'd0);
        step();                                   // edge24: REQ @FFFFFFFC
        chk("wrap.addr", bus.IMemAddr, 32'hFFFF_FFFC);
        step();                                   // edge25: slot
        chk_slot("wrap.slot", 1'b1, 32'h0000_000C, 32'hFFFF_FFFC, 32'h0);
        bus.IMemAck = 1'b0;
        step();                                   // edge26: consume + REQ @0
        chk("wrap.next_addr", bus.IMemAddr, 32'h0);
        chk("wrap.next_req",  {31'd0, bus.IMemReq}, 32'd1);
`ifdef FETCH_PERF_EN
        chk("perf.fetch", FetchCount, 32'd4);
        chk("perf.flush", FlushCount, 32'd4);
`endif

        // Asynchronous reset in the middle of REQ
        #2;
        Reset = 1'b1;
        #1;
        chk("arst.req",  {31'd0, bus.IMemReq}, 32'd0);
        chk("arst.addr", bus.IMemAddr, 32'd0);
        chk_slot("arst", 1'b0, 32'd0, 32'd0, 32'd0);
`ifdef FETCH_PERF_EN
        chk("arst.fetch", FetchCount, 32'd0);
        chk("arst.flush", FlushCount, 32'd0);
`endif
        step();
        Reset = 1'b0;
        step();                                   // first fetch after reset
        chk("arst.refetch_addr", bus.IMemAddr, 32'h0);
        chk("arst.refetch_req",  {31'd0, bus.IMemReq}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
